// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with RAW forwarding and load-use stall.
// Option macro ID_EX_FORWARDING_EN: forward muxes; else stall until MEM drains.
module id_ex_stage #(
   parameter int W     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_dest,
   input  logic [W-1:0]     id_rs_data,
   input  logic [W-1:0]     id_rt_data,
   input  logic [W-1:0]     id_imm,
   input  logic             id_alu_src,
   input  logic [3:0]       id_alu_ctrl,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             id_mem_to_reg,
   input  logic             mem_reg_write,
   input  logic [4:0]       mem_dest,
   input  logic [W-1:0]     mem_result,
   input  logic             wb_reg_write,
   input  logic [4:0]       wb_dest,
   input  logic [W-1:0]     wb_data,
   output logic [W-1:0]     ex_a,
   output logic [W-1:0]     ex_b,
   output logic [W-1:0]     ex_store_data,
   output logic [3:0]       ex_alu_ctrl,
   output logic [4:0]       ex_dest,
   output logic             ex_reg_write,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic             ex_mem_to_reg,
   output logic             ex_valid,
   output logic             stall_id,
   output logic [CNT_W-1:0] stall_count
);

   logic [W-1:0] rs_q;
   logic [W-1:0] rt_q;
   logic [W-1:0] imm_q;
   logic         alu_src_q;
   logic         hazard;
   logic         bubble;
   logic [W-1:0] fwd_rs;
   logic [W-1:0] fwd_rt;

`ifdef ID_EX_FORWARDING_EN
   logic [4:0] rs_n_q;
   logic [4:0] rt_n_q;

   assign hazard = ex_valid & ex_mem_read
                 & (ex_dest != 5'd0) & id_valid
                 & ((ex_dest == id_rs) | (ex_dest == id_rt));

   // MEM holds the younger producer, so it beats WB
   always_comb begin
      fwd_rs = rs_q;
      if (mem_reg_write && mem_dest != 5'd0
          && mem_dest == rs_n_q)
         fwd_rs = mem_result;
      else if (wb_reg_write && wb_dest != 5'd0
               && wb_dest == rs_n_q)
         fwd_rs = wb_data;
   end

   always_comb begin
      fwd_rt = rt_q;
      if (mem_reg_write && mem_dest != 5'd0
          && mem_dest == rt_n_q)
         fwd_rt = mem_result;
      else if (wb_reg_write && wb_dest != 5'd0
               && wb_dest == rt_n_q)
         fwd_rt = wb_data;
   end

   always_ff @(posedge clk) begin
      if (reset || bubble) begin
         rs_n_q <= 5'd0;
         rt_n_q <= 5'd0;
      end else begin
         rs_n_q <= id_rs;
         rt_n_q <= id_rt;
      end
   end
`else
   logic rs_busy;
   logic rt_busy;
   logic unused_fwd;

   // write-first regfile: only EX and MEM producers are still in flight
   assign rs_busy = (id_rs != 5'd0)
                  & ((ex_valid & ex_reg_write & (ex_dest == id_rs))
                   | (mem_reg_write & (mem_dest == id_rs)));
   assign rt_busy = (id_rt != 5'd0)
                  & ((ex_valid & ex_reg_write & (ex_dest == id_rt))
                   | (mem_reg_write & (mem_dest == id_rt)));
   assign hazard  = id_valid & (rs_busy | rt_busy);

   assign fwd_rs = rs_q;
   assign fwd_rt = rt_q;

   assign unused_fwd = ^{mem_result, wb_reg_write, wb_dest, wb_data};
`endif

   assign bubble        = flush | hazard | ~id_valid;
   assign stall_id      = hazard & ~flush;
   assign ex_a          = fwd_rs;
   assign ex_store_data = fwd_rt;
   assign ex_b          = alu_src_q ? imm_q : fwd_rt;

   always_ff @(posedge clk) begin
      if (reset || bubble) begin
         ex_valid      <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_alu_ctrl   <= 4'd0;
         ex_dest       <= 5'd0;
         alu_src_q     <= 1'b0;
         rs_q          <= '0;
         rt_q          <= '0;
         imm_q         <= '0;
      end else begin
         ex_valid      <= 1'b1;
         ex_reg_write  <= id_reg_write;
         ex_mem_read   <= id_mem_read;
         ex_mem_write  <= id_mem_write;
         ex_mem_to_reg <= id_mem_to_reg;
         ex_alu_ctrl   <= id_alu_ctrl;
         ex_dest       <= id_dest;
         alu_src_q     <= id_alu_src;
         rs_q          <= id_rs_data;
         rt_q          <= id_rt_data;
         imm_q         <= id_imm;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_count <= '0;
      else if (stall_id && stall_count != '1)
         stall_count <= stall_count + CNT_W'(1);
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with operand forwarding and load-use hazard detection for the 5-stage MIPS datapath. It captures decoded operands and control at each clock and resolves RAW hazards by forwarding from MEM/WB or by stalling ID. It drives the ALU operand/control inputs and the EX-stage control bundle. Downstream is the ALU and EX/MEM register; upstream is the decode stage and IF/ID register.

## Interface
Parameters:
- `W`, 32: datapath width.
- `CNT_W`, 16: stall counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `flush` in 1: kill the instruction currently in ID (branch taken); loads a bubble.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt`, `id_dest` in 5 each: source and destination register numbers.
- `id_rs_data`, `id_rt_data`, `id_imm` in W each: register-file reads and sign-extended immediate.
- `id_alu_src` in 1: 1 selects `id_imm` for B.
- `id_alu_ctrl` in 4: ALU operation code.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg` in 1 each: control.
- `mem_reg_write` in 1, `mem_dest` in 5, `mem_result` in W: EX/MEM writeback info.
- `wb_reg_write` in 1, `wb_dest` in 5, `wb_data` in W: MEM/WB writeback info.
- `ex_a`, `ex_b` out W: ALU operands (combinational from stage regs + forwarding).
- `ex_store_data` out W: forwarded rt for stores.
- `ex_alu_ctrl` out 4, `ex_dest` out 5.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_valid` out 1 each.
- `stall_id` out 1: freeze PC and IF/ID (combinational).
- `stall_count` out CNT_W: saturating count of stall cycles.

## Operation
- Per-edge priority: `reset` > `flush` > hazard bubble > normal capture.
- Reset: all stage registers, `ex_valid`, and `stall_count` are 0. Outputs are then `ex_a` = `ex_b` = `ex_store_data` = 0, all controls are 0, and `stall_id` = 0.
- Bubble (flush, hazard, or `id_valid` = 0): `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, and `ex_mem_to_reg` are 0. Data fields are don't-care but are zeroed.
- Load-use hazard: `ex_valid` & `ex_mem_read` & `ex_dest` != 0 & `id_valid` & (`ex_dest` == `id_rs` | `ex_dest` == `id_rt`).
- `stall_id` = hazard & ~`flush`. When `flush` coincides with a hazard, the flush wins and no stall is raised.
- Forwarding per source operand (rs, rt captured into the stage):
  - If `mem_reg_write` & `mem_dest` != 0 & `mem_dest` == src, use `mem_result`.
  - Otherwise, if `wb_reg_write` & `wb_dest` != 0 & `wb_dest` == src, use `wb_data`.
  - Otherwise use the captured register data.
  - MEM has priority over WB. Register 0 is never forwarded.
- `ex_a` = forwarded rs.
- `ex_store_data` = forwarded rt.
- `ex_b` = `ex_alu_src` ? `ex_imm` : forwarded rt.
- `stall_count` increments on each edge where `stall_id` = 1 and saturates at all-ones. It is cleared only by `reset`.

## Timing
- Latency: ID inputs are sampled at edge N and visible on `ex_*` after edge N.
- Forward muxes and `stall_id` are combinational within the cycle. `stall_id` depends only on stage registers and ID inputs.
- A load-use stall lasts exactly 1 cycle. At the next edge the load is in MEM, its data arrives via the `wb_*` path one cycle later, and the dependent instruction re-presented in ID is captured normally.
- `reset` asserted mid-stream overrides the pending capture or stall at that edge.

## Configuration
- Macro: `ID_EX_FORWARDING_EN`.
- Defined: behaviour as above.
- Undefined:
  - Forward muxes are removed; operands come from the captured register data only.
  - Hazard becomes any ID source (rs or rt, non-zero) matching `ex_dest` with `ex_reg_write` & `ex_valid`, or matching `mem_dest` with `mem_reg_write`.
  - The register file is write-first, so WB needs no stall.
  - A stall holds until the producer leaves MEM: 2 cycles for a back-to-back dependence.

## Test plan
- Reset with all inputs high: after the edge, `ex_valid` = 0, `ex_a` = 0, `stall_id` = 0, `stall_count` = 0.
- `add $3,$1,$2` then `sub $4,$3,$1` with `mem_result` = 0x0000_0010: `ex_a` = 0x10 in the sub's EX cycle. If WB also targets $3 with 0x20, MEM still wins and `ex_a` = 0x10.
- `lw $5` in EX with dependent `add $6,$5,$5` in ID: `stall_id` = 1 for one cycle, a bubble appears (`ex_valid` = 0), `stall_count` = 1, and the add then receives `wb_data` 0xDEAD_BEEF on both operands.
- `mem_dest` = 0 with `mem_reg_write` = 1 and `mem_result` = 0x55, ID reads $0: `ex_a` = 0.
- `flush` = 1 together with a load-use hazard: `stall_id` = 0 and `ex_valid` = 0 after the edge.
- With `ID_EX_FORWARDING_EN` undefined, back-to-back `add $3` then `or $7,$3,$3`: `stall_id` = 1 for 2 cycles and `stall_count` = 2.
